turn_manager: RTL and testbench
===============================

TURN_MANAGER -- requirements
Module: turn_manager

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, player count; legal range 2..8.
REQ-002 Parameter HP_W, default 8, width of each hit-point counter.
REQ-003 Parameter HP_MAX, default 100, starting hit points per player.
REQ-004 Parameter DAMAGE, default 25, hit points removed per hit.
REQ-005 Parameter TURN_FRAMES, default 255, turn length in frames; range 1..255.
REQ-006 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-007 Port reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port frame_clk, input, 1, vertical sync level, sampled in the clk domain.
REQ-009 Port start, input, 1, request to begin a game.
REQ-010 Port fire, input, 1, active player's fire request (level).
REQ-011 Port exploded, input, 1, bomb explosion complete (level).
REQ-012 Port hit, input, NUM_PLAYERS, mask of players damaged; valid while exploded=1.
REQ-013 Port active, output, NUM_PLAYERS, one-hot current player; all-zero in IDLE.
REQ-014 Port fire_ack, output, 1, one-cycle pulse launching the active player's bomb.
REQ-015 Port hp, output, NUM_PLAYERS*HP_W, packed hit points; player i at [i*HP_W +: HP_W].
REQ-016 Port timer, output, 8, frames remaining in the current turn.
REQ-017 Port game_over, output, 1, high in state OVER.
REQ-018 Port winner, output, 3, index of the surviving player when game_over=1.
REQ-019 Port draw, output, 1, high in OVER when no player survives.

Function
REQ-020 Frame tick SHALL be a one-cycle strobe on each rising edge of frame_clk, detected with a 2-flop sampler plus a previous-value register.
REQ-021 States SHALL be IDLE, AIM, FLIGHT, SETTLE, NEXT and OVER.
REQ-022 IDLE SHALL wait for start=1, then load every hp with HP_MAX, select player 0 and enter AIM the next cycle.
REQ-023 On AIM entry, timer SHALL load TURN_FRAMES and decrement by 1 on each frame tick, saturating at 0.
REQ-024 In AIM, fire=1 SHALL assert fire_ack for exactly one cycle and enter FLIGHT.
REQ-025 In FLIGHT, exploded=1 SHALL subtract DAMAGE from every hp with its hit bit set, saturating at 0, then enter SETTLE.
REQ-026 exploded and hit SHALL be ignored in every state except FLIGHT; fire SHALL be ignored in every state except AIM.
REQ-027 SETTLE SHALL last one cycle: enter OVER if at most one player has hp>0, else enter NEXT.
REQ-028 NEXT SHALL select the next player with hp>0 in increasing index order, wrapping from NUM_PLAYERS-1 to 0, then enter AIM.
REQ-029 A player with hp=0 SHALL never become active.
REQ-030 In OVER, winner SHALL equal the index of the only player with hp>0; if none survive, draw=1 and winner=0.
REQ-031 start=1 in OVER SHALL reinitialise exactly as from IDLE; start SHALL be ignored in all other states.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, active=0, fire_ack=0, every hp=HP_MAX, timer=0, game_over=0, winner=0, draw=0 and clear the frame-edge sampler, including in mid-turn.
REQ-033 The first cycle after release SHALL NOT generate a frame tick.

Configuration
REQ-034 With macro TURN_TIMEOUT_EN defined, timer=0 in AIM SHALL enter NEXT without fire_ack, forfeiting the turn.
REQ-035 If fire=1 in the same cycle that timer reaches 0, fire SHALL take precedence.
REQ-036 Without TURN_TIMEOUT_EN, no turn SHALL time out, timer SHALL read 0 and the timer logic SHALL be absent.

Verification
REQ-037 Apply reset_n=0 mid-FLIGHT with hp0=50. Required: IDLE, hp0=100 and active=0 before the next clk edge.
REQ-038 Drive start, then fire, then exploded with hit=2'b10. Required: one fire_ack; hp1=75; active moves from 01 to 10.
REQ-039 Run four exploded events with hit=2'b10. Required: hp1=0, game_over=1, winner=0, draw=0.
REQ-040 With NUM_PLAYERS=3 and hp1=0, complete a turn from player 0. Required: active jumps to player 2, then wraps to player 0.
REQ-041 With TURN_TIMEOUT_EN and TURN_FRAMES=3, send 3 frame ticks with no fire. Required: timer steps 3,2,1,0; no fire_ack; next player active.
REQ-042 Drive exploded with hit=2'b11 when both players have hp=25. Required: both hp=0, game_over=1, draw=1.

Source files
------------

// File: rtl/turn_manager.sv
// Turn sequencer for an N-player artillery game: hit points, active player, turn timer, win/draw.
// Latency: one clk per FSM step; fire_ack is registered and is high during the first FLIGHT cycle.
// Backpressure: none; fire/exploded are levels consumed only in AIM/FLIGHT and ignored elsewhere.
//
// Ports: clk, reset_n (async, active-low); frame_clk (vsync level, resampled here);
//        start / fire / exploded / hit[NUM_PLAYERS] game inputs;
//        active (one-hot, zero in IDLE), fire_ack (1-cycle pulse), hp (packed, player i at [i*HP_W +: HP_W]),
//        timer (frames left), game_over, winner (survivor index), draw.
// Optional feature: define TURN_TIMEOUT_EN to add the per-turn frame timer and forfeit on expiry;
//        without it timer reads 0 and no timer/sampler logic exists.
module turn_manager #(
    parameter int NUM_PLAYERS = 2,
    parameter int HP_W        = 8,
    parameter int HP_MAX      = 100,
    parameter int DAMAGE      = 25,
    parameter int TURN_FRAMES = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        frame_clk,
    input  logic                        start,
    input  logic                        fire,
    input  logic                        exploded,
    input  logic [NUM_PLAYERS-1:0]      hit,
    output logic [NUM_PLAYERS-1:0]      active,
    output logic                        fire_ack,
    output logic [NUM_PLAYERS*HP_W-1:0] hp,
    output logic [7:0]                  timer,
    output logic                        game_over,
    output logic [2:0]                  winner,
    output logic                        draw
);
    localparam logic [HP_W-1:0] HP_INIT = HP_W'(HP_MAX);
    localparam logic [HP_W-1:0] HP_DMG  = HP_W'(DAMAGE);

    typedef enum logic [2:0] {
        S_IDLE, S_AIM, S_FLIGHT, S_SETTLE, S_NEXT, S_OVER
    } state_t;

    state_t                           state_q, state_d;
    logic [2:0]                       cur_q, cur_d;
    logic [NUM_PLAYERS-1:0][HP_W-1:0] hp_q, hp_d;
    logic                             fire_ack_q, fire_ack_d;
    logic                             timeout;

    // Survivor bookkeeping; alive8 is padded to 8 so a 3-bit index never runs off the end.
    logic [7:0] alive8;
    logic [3:0] alive_cnt;
    logic [2:0] last_alive;
    logic [2:0] nxt_idx;
    logic [3:0] cand;

    always_comb begin
        alive8     = '0;
        alive_cnt  = '0;
        last_alive = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (hp_q[i] != '0) begin
                alive8[i]  = 1'b1;
                alive_cnt  = alive_cnt + 4'd1;
                last_alive = 3'(i);
            end
        end
    end

    // Scan offsets from far to near so the nearest living successor wins.
    always_comb begin
        nxt_idx = cur_q;
        cand    = '0;
        for (int off = NUM_PLAYERS - 1; off >= 1; off--) begin
            cand = {1'b0, cur_q} + 4'(off);
            if (cand >= 4'(NUM_PLAYERS)) begin
                cand = cand - 4'(NUM_PLAYERS);
            end
            if (alive8[cand[2:0]]) begin
                nxt_idx = cand[2:0];
            end
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam logic [7:0] TIMER_INIT = 8'(TURN_FRAMES);

    logic       sync1_q, sync2_q, prev_q;
    logic       frame_tick;
    logic [7:0] timer_q, timer_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign frame_tick = sync2_q & ~prev_q;

    always_comb begin
        timer_d = timer_q;
        if (state_d == S_AIM && state_q != S_AIM) begin
            timer_d = TIMER_INIT;
        end else if (state_q == S_AIM && frame_tick && timer_q != 8'd0) begin
            timer_d = timer_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= 8'd0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer   = timer_q;
    assign timeout = (timer_q == 8'd0);
`else
    logic unused_frame_clk;
    assign unused_frame_clk = frame_clk;
    assign timer            = 8'd0;
    assign timeout          = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        hp_d       = hp_q;
        fire_ack_d = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    hp_d    = {NUM_PLAYERS{HP_INIT}};
                    cur_d   = 3'd0;
                    state_d = S_AIM;
                end
            end
            S_AIM: begin
                // fire wins over an expiring timer
                if (fire) begin
                    fire_ack_d = 1'b1;
                    state_d    = S_FLIGHT;
                end else if (timeout) begin
                    state_d = S_NEXT;
                end
            end
            S_FLIGHT: begin
                if (exploded) begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (hit[i]) begin
                            hp_d[i] = (hp_q[i] > HP_DMG) ? hp_q[i] - HP_DMG : '0;
                        end
                    end
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: state_d = (alive_cnt <= 4'd1) ? S_OVER : S_NEXT;
            S_NEXT: begin
                cur_d   = nxt_idx;
                state_d = S_AIM;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cur_q      <= 3'd0;
            hp_q       <= {NUM_PLAYERS{HP_INIT}};
            fire_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            hp_q       <= hp_d;
            fire_ack_q <= fire_ack_d;
        end
    end

    always_comb begin
        active = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            active[i] = (state_q != S_IDLE) && (cur_q == 3'(i));
        end
    end

    assign fire_ack  = fire_ack_q;
    assign hp        = hp_q;
    assign game_over = (state_q == S_OVER);
    assign draw      = game_over && (alive_cnt == 4'd0);
    assign winner    = (game_over && alive_cnt == 4'd1) ? last_alive : 3'd0;
endmodule

// File: tb/tb_turn_manager.sv
module tb_turn_manager;
    localparam int DMG = 25;
    localparam int HPM = 100;
    localparam int TF3 = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic [1:0]  start_v = '0;
    logic [1:0]  fire_v = '0;
    logic [1:0]  expl_v = '0;
    logic [1:0]  hit2 = '0;
    logic [2:0]  hit3 = '0;

    logic [1:0]  act2;
    logic        fa2, go2, dr2;
    logic [15:0] hp2;
    logic [7:0]  tmr2;
    logic [2:0]  win2;
    logic [2:0]  act3;
    logic        fa3, go3, dr3;
    logic [23:0] hp3;
    logic [7:0]  tmr3;
    logic [2:0]  win3;

    always #5 clk = ~clk;

    turn_manager #(.NUM_PLAYERS(2)) u2 (
        .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk),
        .start(start_v[0]), .fire(fire_v[0]), .exploded(expl_v[0]), .hit(hit2),
        .active(act2), .fire_ack(fa2), .hp(hp2), .timer(tmr2),
        .game_over(go2), .winner(win2), .draw(dr2)
    );

    turn_manager #(.NUM_PLAYERS(3), .TURN_FRAMES(TF3)) u3 (
        .clk(clk), .reset_n(reset_n), .frame_clk(frame_clk),
        .start(start_v[1]), .fire(fire_v[1]), .exploded(expl_v[1]), .hit(hit3),
        .active(act3), .fire_ack(fa3), .hp(hp3), .timer(tmr3),
        .game_over(go3), .winner(win3), .draw(dr3)
    );

    int n_chk = 0;
    int n_pass = 0;
    int fa_cnt[2] = '{0, 0};

    always @(posedge clk) begin
        if (fa2) fa_cnt[0]++;
        if (fa3) fa_cnt[1]++;
    end

    // Reference model: game-level view (phase 0 idle, 1 playing, 2 over).
    int np[2] = '{2, 3};
    int m_hp[2][8];
    int m_cur[2];
    int m_ph[2];

    function automatic logic [31:0] o_hp(input int d, input int i);
        if (d == 0) return 32'(hp2[i*8 +: 8]);
        return 32'(hp3[i*8 +: 8]);
    endfunction
    function automatic logic [31:0] o_act(input int d);
        return (d == 0) ? 32'(act2) : 32'(act3);
    endfunction
    function automatic logic [31:0] o_go(input int d);
        return (d == 0) ? 32'(go2) : 32'(go3);
    endfunction
    function automatic logic [31:0] o_win(input int d);
        return (d == 0) ? 32'(win2) : 32'(win3);
    endfunction
    function automatic logic [31:0] o_draw(input int d);
        return (d == 0) ? 32'(dr2) : 32'(dr3);
    endfunction
    function automatic logic [31:0] o_tmr(input int d);
        return (d == 0) ? 32'(tmr2) : 32'(tmr3);
    endfunction
    function automatic logic [31:0] o_fa(input int d);
        return (d == 0) ? 32'(fa2) : 32'(fa3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input int d, input string tag);
        int cnt;
        int idx;
        cnt = 0;
        idx = 0;
        for (int i = 0; i < np[d]; i++) begin
            chk($sformatf("%s.d%0d.hp%0d", tag, d, i), o_hp(d, i), 32'(m_hp[d][i]));
            if (m_hp[d][i] > 0) begin
                cnt++;
                idx = i;
            end
        end
        if (m_ph[d] == 0) chk($sformatf("%s.d%0d.active", tag, d), o_act(d), 0);
        if (m_ph[d] == 1) chk($sformatf("%s.d%0d.active", tag, d), o_act(d), 32'(1 << m_cur[d]));
        chk($sformatf("%s.d%0d.game_over", tag, d), o_go(d), 32'(m_ph[d] == 2));
        if (m_ph[d] == 2) begin
            chk($sformatf("%s.d%0d.winner", tag, d), o_win(d), 32'((cnt == 1) ? idx : 0));
            chk($sformatf("%s.d%0d.draw", tag, d), o_draw(d), 32'(cnt == 0));
        end else begin
            chk($sformatf("%s.d%0d.winner", tag, d), o_win(d), 0);
            chk($sformatf("%s.d%0d.draw", tag, d), o_draw(d), 0);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ph[d]  = 0;
            m_cur[d] = 0;
            for (int i = 0; i < 8; i++) m_hp[d][i] = HPM;
        end
    endtask

    // After a shot lands: game ends with at most one survivor, else nearest living successor plays.
    task automatic model_advance(input int d);
        int cnt;
        bit found;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < np[d]; i++) if (m_hp[d][i] > 0) cnt++;
        if (cnt <= 1) begin
            m_ph[d] = 2;
        end else begin
            for (int off = 1; off < np[d]; off++) begin
                if (!found && m_hp[d][(m_cur[d] + off) % np[d]] > 0) begin
                    m_cur[d] = (m_cur[d] + off) % np[d];
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic set_hit(input int d, input int mask);
        if (d == 0) hit2 = 2'(mask);
        else hit3 = 3'(mask);
    endtask

    task automatic start_game(input int d);
        @(negedge clk);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        if (m_ph[d] != 1) begin
            for (int i = 0; i < 8; i++) m_hp[d][i] = HPM;
            m_cur[d] = 0;
            m_ph[d]  = 1;
        end
        check_model(d, "start");
    endtask

    task automatic play_turn(input int d, input int mask, input string tag);
`ifdef TURN_TIMEOUT_EN
        chk({tag, ".timer_load"}, o_tmr(d), 32'((d == 0) ? 255 : TF3));
`else
        chk({tag, ".timer_zero"}, o_tmr(d), 0);
`endif
        if ($urandom_range(0, 1) == 1) begin
            // explosion outside FLIGHT must not touch hit points
            expl_v[d] = 1'b1;
            set_hit(d, 7);
            @(negedge clk);
            expl_v[d] = 1'b0;
            set_hit(d, 0);
            check_model(d, {tag, ".ign_expl"});
        end
        if ($urandom_range(0, 3) == 0) begin
            start_v[d] = 1'b1;
            @(negedge clk);
            start_v[d] = 1'b0;
            check_model(d, {tag, ".ign_start"});
        end
        fire_v[d] = 1'b1;
        @(negedge clk);
        chk({tag, ".fire_ack_hi"}, o_fa(d), 1);
        @(negedge clk);
        chk({tag, ".fire_ack_lo"}, o_fa(d), 0);
        fire_v[d] = 1'b0;
        expl_v[d] = 1'b1;
        set_hit(d, mask);
        @(negedge clk);
        expl_v[d] = 1'b0;
        set_hit(d, 0);
        for (int i = 0; i < np[d]; i++) begin
            if (((mask >> i) & 1) == 1) m_hp[d][i] = (m_hp[d][i] > DMG) ? m_hp[d][i] - DMG : 0;
        end
        check_model(d, {tag, ".hit"});
        model_advance(d);
        repeat (2) @(negedge clk);
        check_model(d, {tag, ".after"});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_model(d, "reset");
            chk($sformatf("reset.d%0d.timer", d), o_tmr(d), 0);
            chk($sformatf("reset.d%0d.fire_ack", d), o_fa(d), 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check_model(0, "release");
        check_model(1, "release");

        // Two players: single hit on player 1, then three more until it dies.
        start_game(0);
        fa0 = fa_cnt[0];
        play_turn(0, 2'b10, "t038");
        chk("t038.one_fire_ack", 32'(fa_cnt[0] - fa0), 1);
        chk("t038.hp1", o_hp(0, 1), 75);
        chk("t038.active", o_act(0), 2);
        for (int k = 0; k < 3; k++) play_turn(0, 2'b10, "t039");
        chk("t039.hp1", o_hp(0, 1), 0);
        chk("t039.game_over", o_go(0), 1);
        chk("t039.winner", o_win(0), 0);
        chk("t039.draw", o_draw(0), 0);

        // Restart from OVER, then mutual destruction.
        start_game(0);
        for (int k = 0; k < 3; k++) play_turn(0, 2'b11, "t042a");
        chk("t042.hp0_25", o_hp(0, 0), 25);
        play_turn(0, 2'b11, "t042");
        chk("t042.draw", o_draw(0), 1);
        chk("t042.game_over", o_go(0), 1);

        // Three players: dead player 1 is skipped, then wrap back to 0.
        start_game(1);
        for (int k = 0; k < 4; k++) play_turn(1, 3'b010, "t040a");
        chk("t040.skip_to_p2", o_act(1), 3'b100);
        play_turn(1, 3'b000, "t040b");
        chk("t040.wrap_to_p0", o_act(1), 3'b001);

        // Asynchronous reset in the middle of FLIGHT with hp0=50.
        start_game(0);
        play_turn(0, 2'b01, "t037a");
        play_turn(0, 2'b01, "t037b");
        chk("t037.hp0_50", o_hp(0, 0), 50);
        @(negedge clk);
        fire_v[0] = 1'b1;
        @(negedge clk);
        fire_v[0] = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("t037.hp0", o_hp(0, 0), 100);
        chk("t037.active", o_act(0), 0);
        chk("t037.fire_ack", o_fa(0), 0);
        chk("t037.game_over", o_go(0), 0);
        check_model(0, "t037");
        check_model(1, "t037");
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised games on both instances.
        for (int g = 0; g < 6; g++) begin
            int d;
            d = g % 2;
            start_game(d);
            for (int t = 0; t < 40; t++) begin
                if (m_ph[d] == 1) play_turn(d, int'($urandom_range(0, (1 << np[d]) - 1)), $sformatf("rnd%0d", g));
            end
        end

`ifdef TURN_TIMEOUT_EN
        // Turn forfeited after TF3 frame ticks without fire.
        start_game(1);
        if (m_ph[1] != 1) start_game(1);
        chk("t041.timer3", o_tmr(1), TF3);
        fa0 = fa_cnt[1];
        for (int p = 1; p <= TF3; p++) begin
            frame_clk = 1'b1;
            repeat (3) @(negedge clk);
            chk($sformatf("t041.timer_step%0d", p), o_tmr(1), 32'(TF3 - p));
            frame_clk = 1'b0;
            if (p < TF3) repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        model_advance(1);
        check_model(1, "t041");
        chk("t041.no_fire_ack", 32'(fa_cnt[1] - fa0), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
